noc_sw_alloc: RTL and testbench

NOC_SW_ALLOC -- requirements
Module: noc_sw_alloc

---
 rtl/noc_pkg.sv | 14 +
 rtl/noc_rr_out_arb.sv | 79 +++++++
 rtl/noc_sw_alloc.sv | 86 ++++++++
 tb/tb_noc_sw_alloc.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared constants and types for the switch allocator
package noc_pkg;

    localparam int NPORT = 5;
    localparam int AW    = 3;

    typedef logic [AW-1:0] port_addr_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

endpackage

// File: rtl/noc_rr_out_arb.sv
// rtl/noc_rr_out_arb.sv - per-output round-robin arbiter holding the output until tail or abort
module noc_rr_out_arb #(
    parameter int NPORT = noc_pkg::NPORT,
    parameter int AW    = noc_pkg::AW
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NPORT-1:0] req_i,
    input  logic [NPORT-1:0] req_valid_i,
    input  logic [NPORT-1:0] xfer_i,
    input  logic [NPORT-1:0] tail_i,
    output logic             locked_o,
    output logic [AW-1:0]    owner_o
);
    import noc_pkg::*;

    out_state_e      state_q;
    logic [AW-1:0]   owner_q;
    logic [AW-1:0]   rr_ptr_q;
    logic [AW-1:0]   winner;
    logic [AW-1:0]   idx_a;
    logic            found;
    logic            release_owner;
    int              idx;

    // Search starts at rr_ptr_q and wraps; rr_ptr_q is always < NPORT.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_a  = '0;
        for (int k = 0; k < NPORT; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            idx_a = AW'(idx);
            if (!found && req_i[idx_a]) begin
                found  = 1'b1;
                winner = idx_a;
            end
        end
    end

    // Only the owner's handshake matters; losing valid counts as an abort.
    assign release_owner = (xfer_i[owner_q] & tail_i[owner_q]) | ~req_valid_i[owner_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        state_q <= ST_LOCKED;
                        owner_q <= winner;
                    end
                end
                ST_LOCKED: begin
                    if (release_owner) begin
                        state_q <= ST_IDLE;
                        if (int'(owner_q) == NPORT - 1) begin
                            rr_ptr_q <= '0;
                        end else begin
                            rr_ptr_q <= owner_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign locked_o = (state_q == ST_LOCKED);
    assign owner_o  = owner_q;

endmodule

// File: rtl/noc_sw_alloc.sv
// rtl/noc_sw_alloc.sv - switch allocator: request decode, per-output arbiters, grant collection
module noc_sw_alloc #(
    parameter int NPORT = noc_pkg::NPORT,
    parameter int AW    = noc_pkg::AW
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NPORT-1:0]    req_valid_i,
    input  logic [NPORT*AW-1:0] req_port_addr_i,
    input  logic [NPORT-1:0]    xfer_i,
    input  logic [NPORT-1:0]    tail_i,
    output logic [NPORT-1:0]    gnt_o,
    output logic [NPORT*AW-1:0] gnt_port_o,
    output logic [NPORT-1:0]    out_lock_o,
    output logic                addr_err_o
);
    import noc_pkg::*;

    logic [NPORT-1:0] req_vec [NPORT];
    logic [AW-1:0]    owner   [NPORT];
    logic [NPORT-1:0] locked;
    logic             addr_bad;
    logic             addr_err_q;

    // Out-of-range addresses never match any output, so they drop out here.
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            req_vec[j] = '0;
            for (int i = 0; i < NPORT; i++) begin
                req_vec[j][i] = req_valid_i[i] && !gnt_o[i]
                              && (int'(req_port_addr_i[i*AW +: AW]) == j);
            end
        end
    end

    always_comb begin
        addr_bad = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (req_valid_i[i] && (int'(req_port_addr_i[i*AW +: AW]) >= NPORT)) begin
                addr_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_bad;
        end
    end

    for (genvar j = 0; j < NPORT; j++) begin : g_out
        noc_rr_out_arb #(
            .NPORT (NPORT),
            .AW    (AW)
        ) u_arb (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .req_i       (req_vec[j]),
            .req_valid_i (req_valid_i),
            .xfer_i      (xfer_i),
            .tail_i      (tail_i),
            .locked_o    (locked[j]),
            .owner_o     (owner[j])
        );
    end

    // Grants are a pure view of arbiter state, so they reset with it.
    always_comb begin
        gnt_o      = '0;
        gnt_port_o = '0;
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (locked[j] && (owner[j] == AW'(i))) begin
                    gnt_o[i]              = 1'b1;
                    gnt_port_o[i*AW +: AW] = AW'(j);
                end
            end
        end
    end

    assign out_lock_o = locked;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_noc_sw_alloc.sv
// tb/tb_noc_sw_alloc.sv - table-driven scoreboard bench for noc_sw_alloc
module tb_noc_sw_alloc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [14:0] req_addr;
    logic [4:0]  xfer;
    logic [4:0]  tail;
    logic [4:0]  gnt;
    logic [14:0] gport;
    logic [4:0]  lock;
    logic        err;

    always #5 clk = ~clk;

    noc_sw_alloc #(.NPORT(5), .AW(3)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .req_valid_i     (req_valid),
        .req_port_addr_i (req_addr),
        .xfer_i          (xfer),
        .tail_i          (tail),
        .gnt_o           (gnt),
        .gnt_port_o      (gport),
        .out_lock_o      (lock),
        .addr_err_o      (err)
    );

    typedef struct {
        logic [4:0]  valid;
        logic [14:0] addr;
        logic [4:0]  xfer;
        logic [4:0]  tail;
        logic [4:0]  gnt;
        logic [14:0] gport;
        logic [4:0]  lock;
        logic        err;
    } vec_t;

    typedef struct {
        logic [4:0]  gnt;
        logic [14:0] gport;
        logic [4:0]  lock;
        logic        err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [14:0] pa(int a0, int a1, int a2, int a3, int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic void add(logic [4:0] v, logic [14:0] a, logic [4:0] x, logic [4:0] t,
                                logic [4:0] g, logic [14:0] gp, logic [4:0] l, logic e);
        vec_t r;
        r.valid = v; r.addr = a; r.xfer = x; r.tail = t;
        r.gnt = g; r.gport = gp; r.lock = l; r.err = e;
        tbl.push_back(r);
    endfunction

    task automatic check(string name, logic [14:0] act, logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(string name, logic [4:0] g, logic [14:0] gp, logic [4:0] l, logic e);
        check($sformatf("%s gnt", name), 15'(gnt), 15'(g));
        check($sformatf("%s gnt_port", name), gport, gp);
        check($sformatf("%s out_lock", name), 15'(lock), 15'(l));
        check($sformatf("%s addr_err", name), 15'(err), 15'(e));
    endtask

    task automatic apply(vec_t v, string name);
        exp_t e;
        req_valid = v.valid;
        req_addr  = v.addr;
        xfer      = v.xfer;
        tail      = v.tail;
        e.gnt = v.gnt; e.gport = v.gport; e.lock = v.lock; e.err = v.err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_all(name, e.gnt, e.gport, e.lock, e.err);
        end
    endtask

    initial begin
        vec_t pr;

        // output 4 single grant and release
        add(5'b00100, pa(0,0,4,0,0), '0, '0, 5'b00100, pa(0,0,4,0,0), 5'b10000, 1'b0);
        add(5'b00100, pa(0,0,4,0,0), 5'b00100, 5'b00100, '0, '0, '0, 1'b0);
        add('0, '0, '0, '0, '0, '0, '0, 1'b0);
        // inputs 0,1,3 contend for output 2
        add(5'b01011, pa(2,2,0,2,0), '0, '0, 5'b00001, pa(2,0,0,0,0), 5'b00100, 1'b0);
        add(5'b01011, pa(2,2,0,2,0), 5'b00001, 5'b00001, '0, '0, '0, 1'b0);
        add(5'b01010, pa(0,2,0,2,0), '0, '0, 5'b00010, pa(0,2,0,0,0), 5'b00100, 1'b0);
        add(5'b01010, pa(0,2,0,2,0), 5'b00010, 5'b00010, '0, '0, '0, 1'b0);
        add(5'b01000, pa(0,0,0,2,0), '0, '0, 5'b01000, pa(0,0,0,2,0), 5'b00100, 1'b0);
        add(5'b01000, pa(0,0,0,2,0), 5'b01000, 5'b01000, '0, '0, '0, 1'b0);
        // rr_ptr of output 2 is 4: input 4 beats input 0, then wraps to 0
        add(5'b10001, pa(2,0,0,0,2), '0, '0, 5'b10000, pa(0,0,0,0,2), 5'b00100, 1'b0);
        add(5'b10001, pa(2,0,0,0,2), 5'b10000, 5'b10000, '0, '0, '0, 1'b0);
        add(5'b00001, pa(2,0,0,0,0), '0, '0, 5'b00001, pa(2,0,0,0,0), 5'b00100, 1'b0);
        add(5'b00001, pa(2,0,0,0,0), 5'b00001, 5'b00001, '0, '0, '0, 1'b0);
        // input 4 owns output 0, tail wraps rr_ptr; bubble while 0,1 wait
        add(5'b10000, pa(0,0,0,0,0), '0, '0, 5'b10000, pa(0,0,0,0,0), 5'b00001, 1'b0);
        add(5'b10011, pa(0,0,0,0,0), 5'b10000, 5'b10000, '0, '0, '0, 1'b0);
        add(5'b00011, pa(0,0,0,0,0), '0, '0, 5'b00001, pa(0,0,0,0,0), 5'b00001, 1'b0);
        // owner re-addresses, non-owner sends tail: grant holds
        add(5'b00011, pa(3,0,0,0,0), 5'b00010, 5'b00010, 5'b00001, pa(0,0,0,0,0), 5'b00001, 1'b0);
        add(5'b00011, pa(0,0,0,0,0), 5'b00001, 5'b00001, '0, '0, '0, 1'b0);
        add(5'b00010, pa(0,0,0,0,0), '0, '0, 5'b00010, pa(0,0,0,0,0), 5'b00001, 1'b0);
        add(5'b00010, pa(0,0,0,0,0), 5'b00010, 5'b00010, '0, '0, '0, 1'b0);
        // bad address: one-cycle error, no grant
        add(5'b00010, pa(0,6,0,0,0), '0, '0, '0, '0, '0, 1'b1);
        add('0, '0, '0, '0, '0, '0, '0, 1'b0);
        // owner 3 aborts on output 1; competitor 0 granted after the bubble
        add(5'b01000, pa(0,0,0,1,0), '0, '0, 5'b01000, pa(0,0,0,1,0), 5'b00010, 1'b0);
        add(5'b01001, pa(1,0,0,1,0), '0, '0, 5'b01000, pa(0,0,0,1,0), 5'b00010, 1'b0);
        add(5'b00001, pa(1,0,0,1,0), '0, '0, '0, '0, '0, 1'b0);
        add(5'b00001, pa(1,0,0,0,0), '0, '0, 5'b00001, pa(1,0,0,0,0), 5'b00010, 1'b0);
        add(5'b00001, pa(1,0,0,0,0), 5'b00001, 5'b00001, '0, '0, '0, 1'b0);
        // all five outputs granted in one cycle
        add(5'b11111, pa(1,2,3,4,0), '0, '0, 5'b11111, pa(1,2,3,4,0), 5'b11111, 1'b0);

        rst_n     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        xfer      = '0;
        tail      = '0;
        #1 rst_n = 1'b0;
        #2;
        check_all("reset", '0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k], $sformatf("vec%0d", k));
        end

        // asynchronous reset mid-packet with every output locked
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", '0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_hold", '0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // rr_ptr[0] back to 0: input 1 must beat input 3
        pr.valid = 5'b01010; pr.addr = pa(0,0,0,0,0); pr.xfer = '0; pr.tail = '0;
        pr.gnt = 5'b00010; pr.gport = pa(0,0,0,0,0); pr.lock = 5'b00001; pr.err = 1'b0;
        apply(pr, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
